reaction_round_ctrl: RTL

Round sequencer for the reaction-timer datapath. Runs a round of NUM_TRIALS reaction trials and, for each trial, loads a random foreperiod, times it in 0.01 s ticks, lights the stimulus LED, and measures the reaction time until stop. Outputs per-trial results, a round average and a display-mode select. It sits between the button edge detectors and LFSR (upstream) and the 7-segment muxer (downstream).

---
 rtl/reaction_round_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/reaction_round_ctrl.sv
// reaction_round_ctrl: reaction-timer round sequencer (foreperiod, reaction timing, round average).
// Define REACTION_FALSE_START_EN to fault a trial on a stop press during the foreperiod.
module reaction_round_ctrl #(
   parameter int TICK_DIV     = 500000,
   parameter int NUM_TRIALS   = 4,
   parameter int MIN_DELAY_CS = 100,
   parameter int TIMEOUT_CS   = 999
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_pulse,
   input  logic        stop_pulse,
   input  logic        show_avg,
   input  logic [8:0]  rand_in,
   output logic        led,
   output logic        busy,
   output logic [2:0]  disp_mode,
   output logic [13:0] disp_value,
   output logic [2:0]  trial_idx,
   output logic        result_valid,
   output logic [9:0]  result_cs,
   output logic        avg_valid,
   output logic [9:0]  avg_cs,
   output logic        false_start
);
   localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int LG = $clog2(NUM_TRIALS);
   typedef enum logic [2:0] {IDLE, ARM, WAIT, REACT, SHOW, FAULT, DONE} state_t;
   state_t state;
   logic [DW-1:0] div;
   logic [9:0] delay_cnt, react_cnt, rec;
   logic [12:0] sum;
   logic timing, tick;
   assign timing = state == WAIT || state == REACT;
   assign tick = timing && div == DW'(TICK_DIV - 1);
   assign rec = stop_pulse ? react_cnt : 10'(TIMEOUT_CS);
   assign busy = state == ARM || timing;
   assign avg_valid = state == DONE;
   always_comb begin
      disp_mode = state == REACT ? 3'd1 :
                  state == SHOW ? 3'd2 :
                  state == DONE ? (show_avg ? 3'd3 : 3'd2) :
                  state == FAULT ? 3'd4 : 3'd0;
      disp_value = state == REACT ? 14'(react_cnt) :
                   state == SHOW ? 14'(result_cs) :
                   state == DONE ? 14'(show_avg ? avg_cs : result_cs) : 14'd0;
   end
`ifndef REACTION_FALSE_START_EN
   assign false_start = 1'b0;
`endif
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         div <= '0;
         delay_cnt <= '0;
         react_cnt <= '0;
         sum <= '0;
         led <= 1'b0;
         trial_idx <= '0;
         result_valid <= 1'b0;
         result_cs <= '0;
         avg_cs <= '0;
`ifdef REACTION_FALSE_START_EN
         false_start <= 1'b0;
`endif
      end else begin
         result_valid <= 1'b0;
`ifdef REACTION_FALSE_START_EN
         false_start <= 1'b0;
`endif
         div <= (timing && !tick) ? div + 1'b1 : '0;
         unique case (state)
            IDLE, DONE: if (start_pulse) begin
               state <= ARM;
               sum <= '0;
               trial_idx <= '0;
               avg_cs <= '0;
            end
            ARM: begin
               delay_cnt <= 10'(MIN_DELAY_CS) + 10'(rand_in);
               state <= WAIT;
            end
            WAIT:
`ifdef REACTION_FALSE_START_EN
               if (stop_pulse) begin
                  state <= FAULT;
                  false_start <= 1'b1;
               end else
`endif
               if (tick) begin
                  delay_cnt <= delay_cnt - 10'd1;
                  if (delay_cnt == 10'd1) begin
                     state <= REACT;
                     react_cnt <= '0;
                     led <= 1'b1;
                  end
               end
            REACT:
               if (stop_pulse || (tick && react_cnt == 10'(TIMEOUT_CS - 1))) begin
                  state <= SHOW;
                  led <= 1'b0;
                  result_valid <= 1'b1;
                  result_cs <= rec;
                  sum <= sum + 13'(rec);
               end else if (tick) begin
                  react_cnt <= react_cnt + 10'd1;
               end
            SHOW: if (start_pulse) begin
               if (trial_idx == 3'(NUM_TRIALS - 1)) begin
                  state <= DONE;
                  avg_cs <= 10'(sum >> LG);
               end else begin
                  trial_idx <= trial_idx + 3'd1;
                  state <= ARM;
               end
            end
            FAULT: if (start_pulse) state <= ARM;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
